feature_writeback: RTL

- Return path from the ALU stage to main_feature_mem: takes updated per-flow cache features from the ALUs and writes them back to the feature memory write port.
- Absorbs memory back-pressure in a small FIFO.
- Forwards in-flight (not yet written) records to the lookup side to prevent read-after-write staleness.
- After reset, sweeps and zeroes the whole memory, and clears a flow's entry when the flow reaches its threshold.

---
 rtl/feature_writeback.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/feature_writeback.sv
// ALU-to-feature-memory write-back: zeroes the memory after reset, then drains a small FIFO of per-flow records.
// Accepted results reach o_wr_* one cycle later at the earliest; i_wr_ready stalls the head, a full FIFO drops results.
module feature_writeback #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_alu_v,
   input  logic [31:0]       i_hash,
   input  logic [7:0]        i_max_pkt_size,
   input  logic [7:0]        i_min_pkt_size,
   input  logic [7:0]        i_max_pkt_arit,
   input  logic [7:0]        i_min_pkt_arit,
   input  logic [159:0]      i_vec_feature,
   input  logic              i_reach_thrh,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [191:0]      o_wr_data,
   input  logic              i_wr_ready,
   input  logic              i_lkp_v,
   input  logic [31:0]       i_lkp_hash,
   output logic              o_fwd_v,
   output logic              o_fwd_hit,
   output logic [191:0]      o_fwd_data,
   output logic              o_init_done,
   output logic              o_full,
   output logic [CNT_W-1:0]  o_drop_cnt,
   output logic [CNT_W-1:0]  o_evict_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic {INIT, RUN} state_t;

   state_t             state;
   logic [ADDR_W-1:0]  sweep_addr;
   logic [ADDR_W-1:0]  addr_mem [DEPTH];
   logic [191:0]       data_mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CW-1:0]      count;

   logic               empty;
   logic               full;
   logic               pop;
   logic               push_ok;
   logic [ADDR_W-1:0]  push_addr;
   logic [191:0]       push_data;
   logic [ADDR_W-1:0]  lkp_addr;
   logic               srch_hit;
   logic [191:0]       srch_data;
   logic [PTR_W-1:0]   idx;
   logic               unused_hash_bits;

   assign unused_hash_bits = ^{i_hash[31:ADDR_W], i_lkp_hash[31:ADDR_W]};

   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign pop       = (state == RUN) && !empty && i_wr_ready;
   assign push_ok   = i_alu_v && (!full || pop);
   assign push_addr = i_hash[ADDR_W-1:0];
   assign push_data = i_reach_thrh ? 192'd0 :
                      {i_vec_feature, i_max_pkt_size, i_min_pkt_size, i_max_pkt_arit, i_min_pkt_arit};
   assign lkp_addr  = i_lkp_hash[ADDR_W-1:0];

   // Held low while reset is asserted so the sweep never issues a write from reset.
   assign o_wr_en   = rst_n && ((state == INIT) || !empty);
   assign o_wr_addr = (state == INIT) ? sweep_addr : (empty ? '0 : addr_mem[rd_ptr]);
   assign o_wr_data = (state == INIT || empty) ? 192'd0 : data_mem[rd_ptr];
   assign o_full    = full;

   // Oldest to newest so the newest match wins; a same-cycle push overrides all.
   always_comb begin
      srch_hit  = 1'b0;
      srch_data = 192'd0;
      idx       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr + PTR_W'(k);
         if ((CW'(k) < count) && (addr_mem[idx] == lkp_addr)) begin
            srch_hit  = 1'b1;
            srch_data = data_mem[idx];
         end
      end
      if (push_ok && (push_addr == lkp_addr)) begin
         srch_hit  = 1'b1;
         srch_data = push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         addr_mem[wr_ptr] <= push_addr;
         data_mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= INIT;
         sweep_addr  <= '0;
         o_init_done <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               if (i_wr_ready) begin
                  sweep_addr <= sweep_addr + 1'b1;
                  if (sweep_addr == '1) begin
                     state       <= RUN;
                     o_init_done <= 1'b1;
                  end
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)      count <= count + CW'(1);
         else if (!push_ok && pop) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_drop_cnt  <= '0;
         o_evict_cnt <= '0;
      end else begin
         if (i_alu_v && !push_ok && (o_drop_cnt != '1))
            o_drop_cnt <= o_drop_cnt + CNT_W'(1);
         if (push_ok && i_reach_thrh && (o_evict_cnt != '1))
            o_evict_cnt <= o_evict_cnt + CNT_W'(1);
      end
   end

   // Memory is still being zeroed during INIT, so pending records are not forwarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_fwd_v    <= 1'b0;
         o_fwd_hit  <= 1'b0;
         o_fwd_data <= 192'd0;
      end else begin
         o_fwd_v    <= i_lkp_v;
         o_fwd_hit  <= i_lkp_v && (state == RUN) && srch_hit;
         o_fwd_data <= (i_lkp_v && (state == RUN) && srch_hit) ? srch_data : 192'd0;
      end
   end

endmodule
